pmic_rail_sequencer: RTL and testbench

//  Power-up/power-down sequencer for NUM_RAILS regulator rails.

---
 rtl/pmic_seq_pkg.sv | 21 ++
 rtl/pmic_tick_gen.sv | 45 ++++
 rtl/pmic_rail_sequencer.sv | 252 +++++++++++++++++++++++++
 tb/tb_pmic_rail_sequencer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pmic_seq_pkg.sv
// ---------------------------------------------------------------------------
// pmic_seq_pkg
//   Shared definitions for the PMIC rail sequencer.
//   - state_e          : sequencer FSM states (3-bit encoding)
//   - TICK_DIV_DEFAULT : default prescaler terminal count (one tick every
//                        TICK_DIV+1 clocks)
// ---------------------------------------------------------------------------
package pmic_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RAMP  = 3'd1,
    ST_DELAY = 3'd2,
    ST_UP    = 3'd3,
    ST_DOWN  = 3'd4,
    ST_FAULT = 3'd5
  } state_e;

  localparam int unsigned TICK_DIV_DEFAULT = 2;

endpackage : pmic_seq_pkg

// File: rtl/pmic_tick_gen.sv
// ---------------------------------------------------------------------------
// pmic_tick_gen
//   Free-running prescaler. The counter runs 0..TICK_DIV and wraps; tick_o is
//   a one-clock pulse while the counter sits at TICK_DIV. The counter is never
//   restarted except by reset.
// Ports
//   clk_i   in  1  clock
//   rst_i   in  1  asynchronous, active-high reset (counter and tick to 0)
//   tick_o  out 1  registered tick pulse
// ---------------------------------------------------------------------------
module pmic_tick_gen
  import pmic_seq_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam int CNT_W = (TICK_DIV > 0) ? $clog2(TICK_DIV + 1) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  always_comb begin
    cnt_d  = (cnt_q == CNT_W'(TICK_DIV)) ? '0 : cnt_q + CNT_W'(1);
    // Registered decode of the next count: tick_q is high exactly in the
    // cycles where cnt_q == TICK_DIV, and is guaranteed low in reset.
    tick_d = (cnt_d == CNT_W'(TICK_DIV));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule : pmic_tick_gen

// File: rtl/pmic_rail_sequencer.sv
// ---------------------------------------------------------------------------
// pmic_rail_sequencer
//   Power-up / power-down sequencer for NUM_RAILS regulator rails. Rails are
//   enabled in ascending order (each waits for its own synchronised pgood,
//   then the latched inter-rail delay) and disabled in descending order.
//   A missing pgood while ramping (timeout) or a lost pgood while up forces
//   all rails off at once and reports the failing rail.
// Ports
//   original_clk in  1          system clock
//   rst          in  1          asynchronous, active-high reset
//   start        in  1          level: 1 = sequence up / stay up, 0 = down
//   clear        in  1          pulse; leaves FAULT when start == 0
//   cfg_delay    in  DELAY_W    ticks between rail steps, latched leaving IDLE
//   pgood        in  NUM_RAILS  asynchronous power-good per rail
//   rail_en      out NUM_RAILS  regulator enables
//   busy         out 1          high in RAMP, DELAY, DOWN
//   all_good     out 1          high only in UP
//   fault        out 1          high only in FAULT
//   fault_rail   out IDX_W      index of the failing rail, held until clear
//   tick         out 1          prescaler pulse
// ---------------------------------------------------------------------------
module pmic_rail_sequencer
  import pmic_seq_pkg::*;
#(
  parameter  int          NUM_RAILS     = 4,
  parameter  int unsigned TICK_DIV      = TICK_DIV_DEFAULT,
  parameter  int          DELAY_W       = 8,
  parameter  int          TIMEOUT_TICKS = 16,
  localparam int          IDX_W         = (NUM_RAILS > 1) ? $clog2(NUM_RAILS) : 1
) (
  input  logic                 original_clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 clear,
  input  logic [DELAY_W-1:0]   cfg_delay,
  input  logic [NUM_RAILS-1:0] pgood,
  output logic [NUM_RAILS-1:0] rail_en,
  output logic                 busy,
  output logic                 all_good,
  output logic                 fault,
  output logic [IDX_W-1:0]     fault_rail,
  output logic                 tick
);

  localparam int TO_W   = $clog2(TIMEOUT_TICKS + 1);
  localparam int WCNT_W = (DELAY_W > TO_W) ? DELAY_W : TO_W;

  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_RAILS - 1);
  localparam logic [WCNT_W-1:0] TIMEOUT  = WCNT_W'(TIMEOUT_TICKS);

  // -------------------------------------------------------------------------
  // Prescaler
  // -------------------------------------------------------------------------
  logic tick_w;

  pmic_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk_i  (original_clk),
    .rst_i  (rst),
    .tick_o (tick_w)
  );

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [WCNT_W-1:0]    wcnt_q, wcnt_d;
  logic [DELAY_W-1:0]   delay_q, delay_d;
  logic [NUM_RAILS-1:0] rail_en_q, rail_en_d;
  logic [IDX_W-1:0]     fault_rail_q, fault_rail_d;
  logic                 busy_q, busy_d;
  logic                 all_good_q, all_good_d;
  logic                 fault_q, fault_d;
  logic [NUM_RAILS-1:0] pg_meta_q, pg_sync_q;

  // Two-flop synchroniser; nothing downstream looks at raw pgood.
  always_ff @(posedge original_clk or posedge rst) begin
    if (rst) begin
      pg_meta_q <= '0;
      pg_sync_q <= '0;
    end else begin
      pg_meta_q <= pgood;
      pg_sync_q <= pg_meta_q;
    end
  end

  // Lowest-index rail whose synchronised pgood is low. Scanning downwards
  // lets the last hit (the lowest index) win.
  logic [IDX_W-1:0] low_fail_idx;
  logic             any_fail;

  always_comb begin
    low_fail_idx = '0;
    any_fail     = 1'b0;
    for (int i = NUM_RAILS - 1; i >= 0; i--) begin
      if (!pg_sync_q[i]) begin
        low_fail_idx = IDX_W'(i);
        any_fail     = 1'b1;
      end
    end
  end

  logic [IDX_W-1:0] idx_inc, idx_dec;
  logic             wcnt_zero;

  assign idx_inc   = idx_q + IDX_W'(1);
  assign idx_dec   = idx_q - IDX_W'(1);
  assign wcnt_zero = (wcnt_q == '0);

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    wcnt_d       = wcnt_q;
    delay_d      = delay_q;
    rail_en_d    = rail_en_q;
    fault_rail_d = fault_rail_q;

    unique case (state_q)
      ST_IDLE: begin
        rail_en_d = '0;
        if (start) begin
          delay_d      = cfg_delay;
          idx_d        = '0;
          rail_en_d[0] = 1'b1;
          wcnt_d       = TIMEOUT;
          state_d      = ST_RAMP;
        end
      end

      ST_RAMP: begin
        // Fault has priority over abort; abort has priority over progress.
        if (tick_w && wcnt_zero && !pg_sync_q[idx_q]) begin
          rail_en_d    = '0;
          fault_rail_d = idx_q;
          state_d      = ST_FAULT;
        end else if (!start) begin
          // Rail idx is the highest one enabled; the pgood wait is dropped.
          rail_en_d[idx_q] = 1'b0;
          wcnt_d           = WCNT_W'(delay_q);
          state_d          = ST_DOWN;
        end else if (pg_sync_q[idx_q]) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_UP;
          end else begin
            wcnt_d  = WCNT_W'(delay_q);
            state_d = ST_DELAY;
          end
        end else if (tick_w) begin
          wcnt_d = wcnt_q - WCNT_W'(1);
        end
      end

      ST_DELAY: begin
        if (!start) begin
          rail_en_d[idx_q] = 1'b0;
          wcnt_d           = WCNT_W'(delay_q);
          state_d          = ST_DOWN;
        end else if (wcnt_zero) begin
          // Checked before the tick so a zero delay advances on the next clock.
          idx_d              = idx_inc;
          rail_en_d[idx_inc] = 1'b1;
          wcnt_d             = TIMEOUT;
          state_d            = ST_RAMP;
        end else if (tick_w) begin
          wcnt_d = wcnt_q - WCNT_W'(1);
        end
      end

      ST_UP: begin
        if (any_fail) begin
          rail_en_d    = '0;
          fault_rail_d = low_fail_idx;
          state_d      = ST_FAULT;
        end else if (!start) begin
          idx_d               = LAST_IDX;
          rail_en_d[LAST_IDX] = 1'b0;
          wcnt_d              = WCNT_W'(delay_q);
          state_d             = ST_DOWN;
        end
      end

      ST_DOWN: begin
        // pgood and start are deliberately ignored here.
        if (idx_q == '0) begin
          state_d = ST_IDLE;
        end else if (wcnt_zero) begin
          idx_d              = idx_dec;
          rail_en_d[idx_dec] = 1'b0;
          wcnt_d             = WCNT_W'(delay_q);
        end else if (tick_w) begin
          wcnt_d = wcnt_q - WCNT_W'(1);
        end
      end

      ST_FAULT: begin
        rail_en_d = '0;
        if (clear && !start) begin
          fault_rail_d = '0;
          state_d      = ST_IDLE;
        end
      end

      default: begin
        rail_en_d = '0;
        state_d   = ST_IDLE;
      end
    endcase

    // Status flags are registered from the next state so they line up with
    // state_q without any combinational decode on the outputs.
    busy_d     = (state_d == ST_RAMP) || (state_d == ST_DELAY) || (state_d == ST_DOWN);
    all_good_d = (state_d == ST_UP);
    fault_d    = (state_d == ST_FAULT);
  end

  always_ff @(posedge original_clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      wcnt_q       <= '0;
      delay_q      <= '0;
      rail_en_q    <= '0;
      fault_rail_q <= '0;
      busy_q       <= 1'b0;
      all_good_q   <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      wcnt_q       <= wcnt_d;
      delay_q      <= delay_d;
      rail_en_q    <= rail_en_d;
      fault_rail_q <= fault_rail_d;
      busy_q       <= busy_d;
      all_good_q   <= all_good_d;
      fault_q      <= fault_d;
    end
  end

  assign rail_en    = rail_en_q;
  assign busy       = busy_q;
  assign all_good   = all_good_q;
  assign fault      = fault_q;
  assign fault_rail = fault_rail_q;
  assign tick       = tick_w;

endmodule : pmic_rail_sequencer

// File: tb/tb_pmic_rail_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pmic_rail_sequencer
//   Directed bench for the rail sequencer (NUM_RAILS=4, TICK_DIV=2,
//   TIMEOUT_TICKS=16). A small regulator model raises pgood two clocks after
//   each rail enable; pg_ok masks individual rails to emulate failures.
// ---------------------------------------------------------------------------
module tb_pmic_rail_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       clear;
  logic [7:0] cfg_delay;
  logic [3:0] pgood;
  logic [3:0] rail_en;
  logic       busy;
  logic       all_good;
  logic       fault;
  logic [1:0] fault_rail;
  logic       tick;

  logic [3:0] pg_d1 = '0;
  logic [3:0] pg_d2 = '0;
  logic [3:0] pg_ok = 4'hF;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    pg_d1 <= rail_en;
    pg_d2 <= pg_d1;
  end

  assign pgood = pg_d2 & pg_ok;

  pmic_rail_sequencer #(
    .NUM_RAILS     (4),
    .TICK_DIV      (2),
    .DELAY_W       (8),
    .TIMEOUT_TICKS (16)
  ) dut (
    .original_clk (clk),
    .rst          (rst),
    .start        (start),
    .clear        (clear),
    .cfg_delay    (cfg_delay),
    .pgood        (pgood),
    .rail_en      (rail_en),
    .busy         (busy),
    .all_good     (all_good),
    .fault        (fault),
    .fault_rail   (fault_rail),
    .tick         (tick)
  );

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int val, input int lo, input int hi);
    checks++;
    assert (val >= lo && val <= hi) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d..%0d", name, val, lo, hi);
    end
  endtask

  task automatic clk_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Waits (bounded) until rail_en equals target; caller checks the result.
  task automatic wait_en(input logic [3:0] target, input int bound);
    int n = 0;
    while (rail_en !== target && n < bound) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_all_good(input int bound);
    int n = 0;
    while (all_good !== 1'b1 && n < bound) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int prev;
    int n;
    logic [3:0] exp_en;
    logic hi_seen;

    rst = 1'b1; start = 1'b0; clear = 1'b0; cfg_delay = 8'd3; pg_ok = 4'hF;
    clk_n(3);

    // ---- reset state ----
    chk("rst_rail_en", rail_en, 4'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_all_good", all_good, 1'b0);
    chk("rst_fault", fault, 1'b0);
    chk("rst_fault_rail", fault_rail, 2'd0);
    chk("rst_tick", tick, 1'b0);
    rst = 1'b0;
    // prescaler from count 0: 1 (no tick), 2 (tick), 0 (no tick)
    clk_n(1); chk("tick_ph1", tick, 1'b0);
    clk_n(1); chk("tick_ph2", tick, 1'b1);
    clk_n(1); chk("tick_ph3", tick, 1'b0);

    // ---- 1: power-up, delay 3 ----
    start = 1'b1;
    wait_en(4'h1, 3);
    chk("up_rail0", rail_en, 4'h1);
    chk("up_busy", busy, 1'b1);
    cfg_delay = 8'd0;  // already latched; must not shorten the spacing
    prev = cyc;
    for (int r = 1; r < 4; r++) begin
      exp_en = 4'((1 << (r + 1)) - 1);
      wait_en(exp_en, 40);
      chk("up_order", rail_en, exp_en);
      chk_rng("up_spacing", cyc - prev, 11, 17);
      chk("up_no_fault", fault, 1'b0);
      prev = cyc;
    end
    wait_all_good(8);
    chk("up_all_good", all_good, 1'b1);
    chk("up_busy_low", busy, 1'b0);
    chk("up_fault_low", fault, 1'b0);

    // ---- 3: power-down from UP ----
    start = 1'b0;
    clk_n(1);
    chk("dn_rail3_off", rail_en, 4'h7);
    chk("dn_busy", busy, 1'b1);
    chk("dn_all_good_low", all_good, 1'b0);
    prev = cyc;
    for (int r = 2; r >= 0; r--) begin
      exp_en = 4'((1 << r) - 1);
      wait_en(exp_en, 20);
      chk("dn_order", rail_en, exp_en);
      chk_rng("dn_spacing", cyc - prev, 7, 11);
      prev = cyc;
    end
    chk("dn_busy_last", busy, 1'b1);
    clk_n(1);
    chk("dn_idle_busy", busy, 1'b0);
    chk("dn_idle_rail_en", rail_en, 4'h0);

    // ---- 2: timeout on rail 2 ----
    cfg_delay = 8'd3;
    pg_ok = 4'b1011;
    clk_n(1);
    start = 1'b1;
    wait_en(4'h7, 60);
    chk("to_rail2_on", rail_en, 4'h7);
    n = 0;
    while (fault !== 1'b1 && n < 80) begin
      @(negedge clk);
      n++;
    end
    chk("to_fault", fault, 1'b1);
    chk_rng("to_latency", n, 45, 51);
    chk("to_fault_rail", fault_rail, 2'd2);
    chk("to_rail_en", rail_en, 4'h0);
    chk("to_busy", busy, 1'b0);
    clear = 1'b1;             // start still 1: ignored
    clk_n(1);
    clear = 1'b0;
    clk_n(1);
    chk("to_clear_ignored", fault, 1'b1);
    chk("to_fault_rail_held", fault_rail, 2'd2);
    start = 1'b0;
    clk_n(1);
    chk("to_no_clear_stays", fault, 1'b1);
    clear = 1'b1;
    clk_n(1);
    clear = 1'b0;
    chk("to_cleared", fault, 1'b0);
    chk("to_idle_busy", busy, 1'b0);
    pg_ok = 4'hF;
    clk_n(3);

    // ---- 4: abort in DELAY after rail 1 is up ----
    start = 1'b1;
    wait_en(4'h3, 60);
    chk("ab_rail1_on", rail_en, 4'h3);
    clk_n(7);  // past pgood sync, inside the 3-tick delay
    chk("ab_in_delay", rail_en, 4'h3);
    start = 1'b0;
    clk_n(1);
    chk("ab_rail1_off", rail_en, 4'h1);
    hi_seen = 1'b0;
    n = 0;
    while (rail_en !== 4'h0 && n < 15) begin
      @(negedge clk);
      hi_seen = hi_seen | (|rail_en[3:2]);
      n++;
    end
    chk("ab_rail0_off", rail_en, 4'h0);
    chk("ab_no_high_rails", hi_seen, 1'b0);
    clk_n(1);
    chk("ab_idle_busy", busy, 1'b0);
    clk_n(3);

    // ---- 5: runtime pgood loss on rails 1 and 3 ----
    start = 1'b1;
    wait_all_good(80);
    chk("rl_all_good", all_good, 1'b1);
    pg_ok = 4'b0101;
    clk_n(2);
    chk("rl_not_yet", fault, 1'b0);
    clk_n(1);
    chk("rl_fault", fault, 1'b1);
    chk("rl_fault_rail", fault_rail, 2'd1);
    chk("rl_rail_en", rail_en, 4'h0);
    chk("rl_all_good_low", all_good, 1'b0);
    start = 1'b0;
    clear = 1'b1;
    clk_n(1);
    clear = 1'b0;
    pg_ok = 4'hF;
    chk("rl_cleared", fault, 1'b0);
    clk_n(3);

    // ---- 6: asynchronous reset mid-RAMP, then delay 0 ----
    cfg_delay = 8'd3;
    start = 1'b1;
    wait_en(4'h1, 3);
    clk_n(2);
    #2 rst = 1'b1;
    #1;
    chk("ar_rail_en", rail_en, 4'h0);
    chk("ar_busy", busy, 1'b0);
    chk("ar_tick", tick, 1'b0);
    start = 1'b0;
    clk_n(3);
    rst = 1'b0;
    clk_n(1); chk("ar_tick_ph1", tick, 1'b0);
    clk_n(1); chk("ar_tick_ph2", tick, 1'b1);
    clk_n(1); chk("ar_tick_ph3", tick, 1'b0);
    cfg_delay = 8'd0;
    start = 1'b1;
    wait_en(4'h1, 3);
    chk("z_rail0", rail_en, 4'h1);
    prev = cyc;
    for (int r = 1; r < 4; r++) begin
      exp_en = 4'((1 << (r + 1)) - 1);
      wait_en(exp_en, 12);
      chk("z_up_order", rail_en, exp_en);
      chk("z_up_spacing", cyc - prev, 6);
      prev = cyc;
    end
    wait_all_good(8);
    chk("z_all_good", all_good, 1'b1);
    start = 1'b0;
    clk_n(1); chk("z_dn0", rail_en, 4'h7);
    clk_n(1); chk("z_dn1", rail_en, 4'h3);
    clk_n(1); chk("z_dn2", rail_en, 4'h1);
    clk_n(1); chk("z_dn3", rail_en, 4'h0);
    clk_n(1); chk("z_idle_busy", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_pmic_rail_sequencer
